// File: rtl/ysyx_22050710_lsu.sv
// ysyx_22050710_lsu
// Memory-stage load/store unit. Accepts one instruction from execute,
// issues at most one aligned 64-bit request on a valid/ready memory port,
// and hands one registered result to write-back.
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_valid / o_ready     upstream handshake (ready only while idle)
//   i_alu_result          effective address for memory ops, else the result
//   i_wdata               store data
//   i_mem_en, i_mem_op    memory op flag; op = {store, unsigned, size[1:0]}
//   o_mem_req_valid / i_mem_req_ready, o_mem_addr, o_mem_wen,
//   o_mem_wdata, o_mem_wmask   memory request channel
//   i_mem_rsp_valid, i_mem_rdata   memory response channel
//   o_valid / i_wb_ready  write-back handshake
//   o_result, o_misalign  write-back payload
module ysyx_22050710_lsu #(
  parameter int WORD_WD = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_WD-1:0] i_alu_result,
  input  logic [WORD_WD-1:0] i_wdata,
  input  logic               i_mem_en,
  input  logic [3:0]         i_mem_op,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [WORD_WD-1:0] o_mem_addr,
  output logic               o_mem_wen,
  output logic [WORD_WD-1:0] o_mem_wdata,
  output logic [7:0]         o_mem_wmask,
  input  logic               i_mem_rsp_valid,
  input  logic [WORD_WD-1:0] i_mem_rdata,
  output logic               o_valid,
  input  logic               i_wb_ready,
  output logic [WORD_WD-1:0] o_result,
  output logic               o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic [WORD_WD-1:0] addr_q;
  logic [WORD_WD-1:0] wdata_q;
  logic [3:0]         op_q;
  logic [WORD_WD-1:0] result_q;
  logic               misalign_q;

  logic               in_misalign;
  logic               accept;
  logic [WORD_WD-1:0] lane;
  logic [WORD_WD-1:0] load_ext;
  logic [7:0]         size_mask;

  assign accept = (state == IDLE) && i_valid;

  // An access is misaligned when the low address bits below the access
  // size are not all zero; a doubleword needs all three clear.
  always_comb begin
    in_misalign = 1'b0;
    case (i_mem_op[1:0])
      2'd0: in_misalign = 1'b0;
      2'd1: in_misalign = i_alu_result[0];
      2'd2: in_misalign = |i_alu_result[1:0];
      2'd3: in_misalign = |i_alu_result[2:0];
      default: in_misalign = 1'b0;
    endcase
  end

  // State register; reset returns to IDLE even in the middle of a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Non-memory and misaligned instructions skip the
  // memory port entirely and go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (!i_mem_en || in_misalign) begin
            state_nxt = DONE;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rsp_valid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_wb_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane-select the returned doubleword, then truncate and extend to the
  // access size. A doubleword load has nothing to extend, so the unsigned
  // bit has no effect there.
  always_comb begin
    lane     = i_mem_rdata >> {addr_q[2:0], 3'b000};
    load_ext = lane;
    case (op_q[1:0])
      2'd0: load_ext = op_q[2] ? {{(WORD_WD-8){1'b0}}, lane[7:0]}
                               : {{(WORD_WD-8){lane[7]}}, lane[7:0]};
      2'd1: load_ext = op_q[2] ? {{(WORD_WD-16){1'b0}}, lane[15:0]}
                               : {{(WORD_WD-16){lane[15]}}, lane[15:0]};
      2'd2: load_ext = op_q[2] ? {{(WORD_WD-32){1'b0}}, lane[31:0]}
                               : {{(WORD_WD-32){lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Capture the instruction on acceptance and the load result on the
  // response. The result register is what write-back sees, so it only
  // changes at those two points and stays stable through a DONE stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= i_alu_result;
      wdata_q    <= i_wdata;
      op_q       <= i_mem_op;
      misalign_q <= i_mem_en && in_misalign;
      result_q   <= i_mem_en ? '0 : i_alu_result;
    end else if ((state == WAIT) && i_mem_rsp_valid) begin
      result_q <= op_q[3] ? '0 : load_ext;
    end
  end

  // Byte-enable pattern for the access size before shifting into its lane.
  always_comb begin
    size_mask = 8'h00;
    case (op_q[1:0])
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0F;
      2'd3: size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  end

  // Request fields are built only from captured registers and are forced
  // to zero outside REQ, so they read as reset values whenever idle.
  always_comb begin
    o_mem_req_valid = (state == REQ);
    o_mem_addr      = '0;
    o_mem_wen       = 1'b0;
    o_mem_wdata     = '0;
    o_mem_wmask     = 8'h00;
    if (state == REQ) begin
      o_mem_addr  = {addr_q[WORD_WD-1:3], 3'b000};
      o_mem_wen   = op_q[3];
      o_mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
      o_mem_wmask = op_q[3] ? (size_mask << addr_q[2:0]) : 8'h00;
    end
  end

  assign o_ready    = (state == IDLE);
  assign o_valid    = (state == DONE);
  assign o_result   = result_q;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// tb_ysyx_22050710_lsu
// Self-checking bench for the load/store unit: directed scenarios followed
// by randomized transactions, compared against a byte-level reference model.
module tb_ysyx_22050710_lsu;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_alu_result;
  logic [63:0] i_wdata;
  logic        i_mem_en;
  logic [3:0]  i_mem_op;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_wen;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rdata;
  logic        o_valid;
  logic        i_wb_ready;
  logic [63:0] o_result;
  logic        o_misalign;

  int checks = 0;
  int errors = 0;

  ysyx_22050710_lsu #(.WORD_WD(64)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_alu_result    (i_alu_result),
    .i_wdata         (i_wdata),
    .i_mem_en        (i_mem_en),
    .i_mem_op        (i_mem_op),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wen       (o_mem_wen),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wmask     (o_mem_wmask),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata),
    .o_valid         (o_valid),
    .i_wb_ready      (i_wb_ready),
    .o_result        (o_result),
    .o_misalign      (o_misalign)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the bench itself ever loses synchronisation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%016h expected 0x%016h",
               tag, $time, actual, expected);
    end
  endtask

  // Reference load: copy the addressed bytes, then fill the upper bytes
  // with the sign byte unless the load is unsigned or a full doubleword.
  function automatic logic [63:0] expLoad(input logic [3:0] op,
                                          input logic [63:0] addr,
                                          input logic [63:0] rdata);
    int nbytes = 1 << op[1:0];
    int off    = int'(addr[2:0]);
    logic [63:0] v = '0;
    for (int b = 0; b < nbytes; b++) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (!op[2] && nbytes < 8 && v[8*nbytes-1])
      for (int b = nbytes; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  // Reference store lane placement: byte b of the data lands in lane off+b.
  function automatic logic [63:0] expWdata(input logic [63:0] addr,
                                           input logic [63:0] wdata);
    int off = int'(addr[2:0]);
    logic [63:0] v = '0;
    for (int b = 0; b + off < 8; b++) v[8*(off+b) +: 8] = wdata[8*b +: 8];
    return v;
  endfunction

  function automatic logic [7:0] expWmask(input logic [3:0] op,
                                          input logic [63:0] addr);
    int nbytes = 1 << op[1:0];
    int off    = int'(addr[2:0]);
    logic [7:0] m = '0;
    for (int b = 0; b < nbytes && off + b < 8; b++) m[off+b] = 1'b1;
    return m;
  endfunction

  // Run one instruction end to end with the given memory and write-back
  // stalls, checking every cycle against the reference model.
  task automatic applyStimulus(input logic mem_en, input logic [3:0] op,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input int req_stall,
                               input int rsp_delay, input int wb_stall);
    int          waited = 0;
    int          nbytes = 1 << op[1:0];
    logic        misal  = mem_en && ((addr % 64'(nbytes)) != 0);
    logic [63:0] exp_res;
    while (!o_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("ready_before_accept", o_ready, 1);
    i_valid      = 1'b1;
    i_alu_result = addr;
    i_wdata      = wdata;
    i_mem_en     = mem_en;
    i_mem_op     = op;
    @(posedge clk); #1;
    i_valid      = 1'b0;
    i_alu_result = {$urandom, $urandom};
    i_wdata      = {$urandom, $urandom};
    i_mem_en     = 1'($urandom_range(0, 1));
    i_mem_op     = 4'($urandom_range(0, 15));
    checkOutput("ready_after_accept", o_ready, 0);
    if (!mem_en || misal) begin
      checkOutput("no_mem_req", o_mem_req_valid, 0);
      exp_res = mem_en ? 64'd0 : addr;
    end else begin
      for (int c = 0; c <= req_stall; c++) begin
        checkOutput("req_valid", o_mem_req_valid, 1);
        checkOutput("req_addr", o_mem_addr, {addr[63:3], 3'b000});
        checkOutput("req_wen", o_mem_wen, op[3]);
        if (op[3]) checkOutput("req_wdata", o_mem_wdata, expWdata(addr, wdata));
        checkOutput("req_wmask", o_mem_wmask, op[3] ? expWmask(op, addr) : 8'h00);
        checkOutput("valid_in_req", o_valid, 0);
        i_mem_req_ready = (c == req_stall);
        i_mem_rsp_valid = 1'($urandom_range(0, 1));
        i_mem_rdata     = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      i_mem_req_ready = 1'b0;
      i_mem_rsp_valid = 1'b0;
      checkOutput("req_dropped", o_mem_req_valid, 0);
      for (int c = 0; c < rsp_delay; c++) begin
        checkOutput("valid_in_wait", o_valid, 0);
        @(posedge clk); #1;
      end
      i_mem_rsp_valid = 1'b1;
      i_mem_rdata     = rdata;
      @(posedge clk); #1;
      i_mem_rsp_valid = 1'b0;
      i_mem_rdata     = {$urandom, $urandom};
      exp_res = op[3] ? 64'd0 : expLoad(op, addr, rdata);
    end
    for (int c = 0; c <= wb_stall; c++) begin
      checkOutput("wb_valid", o_valid, 1);
      checkOutput("wb_result", o_result, exp_res);
      checkOutput("wb_misalign", o_misalign, misal);
      checkOutput("wb_no_req", o_mem_req_valid, 0);
      i_wb_ready      = (c == wb_stall);
      i_mem_rsp_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_wb_ready      = 1'b0;
    i_mem_rsp_valid = 1'b0;
    checkOutput("drained_valid", o_valid, 0);
    checkOutput("drained_ready", o_ready, 1);
  endtask

  // All externally visible outputs must match their reset values.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, o_ready, 1);
    checkOutput({tag, "_req_valid"}, o_mem_req_valid, 0);
    checkOutput({tag, "_wen"}, o_mem_wen, 0);
    checkOutput({tag, "_wmask"}, o_mem_wmask, 0);
    checkOutput({tag, "_addr"}, o_mem_addr, 0);
    checkOutput({tag, "_wdata"}, o_mem_wdata, 0);
    checkOutput({tag, "_valid"}, o_valid, 0);
    checkOutput({tag, "_result"}, o_result, 0);
    checkOutput({tag, "_misalign"}, o_misalign, 0);
  endtask

  // Directed scenarios, mid-request reset, then randomized traffic.
  initial begin
    rst = 1'b1; i_valid = 1'b0; i_alu_result = '0; i_wdata = '0;
    i_mem_en = 1'b0; i_mem_op = '0; i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0; i_mem_rdata = '0; i_wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    applyStimulus(1'b0, 4'b0000, 64'h1234, 64'h0, 64'h0, 0, 0, 3);
    applyStimulus(1'b1, 4'b0000, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0, 0, 0);
    applyStimulus(1'b1, 4'b0100, 64'h80000003, 64'h0, 64'h00000000_80FF0000, 0, 0, 0);
    applyStimulus(1'b1, 4'b1001, 64'h80000006, 64'hABCD, 64'hDEAD, 0, 0, 1);
    applyStimulus(1'b1, 4'b0010, 64'h80000002, 64'h0, 64'h0, 0, 0, 0);
    applyStimulus(1'b1, 4'b0011, 64'h80000008, 64'h0, 64'h01234567_89ABCDEF, 4, 4, 0);

    i_valid = 1'b1; i_alu_result = 64'h80000010; i_mem_en = 1'b1; i_mem_op = 4'b0011;
    @(posedge clk); #1;
    i_valid = 1'b0; i_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_req_ready = 1'b0;
    checkOutput("wait_no_req", o_mem_req_valid, 0);
    checkOutput("wait_not_ready", o_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetState("midreset");
    i_mem_rsp_valid = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    i_mem_rsp_valid = 1'b0;
    checkResetState("stray_rsp");
    applyStimulus(1'b1, 4'b0001, 64'h80000012, 64'h0, 64'h0000_0000_8001_0000, 1, 1, 1);

    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_lsu.md
# ysyx_22050710_lsu

Memory-stage load/store unit sitting directly downstream of the execute-stage ALU. Takes the ALU result as an effective address, or as a pass-through value for non-memory instructions, and issues one aligned 64-bit request on a valid/ready memory port. For loads it lane-selects and sign/zero-extends the returned data. It presents one registered result per instruction to write-back, handshaking with ready/valid on both sides.

## Interface
- WORD_WD, 64, datapath width; only 64 is supported.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  LSU can accept; high only in IDLE.
- i_alu_result  input  WORD_WD  ALU output: effective address when i_mem_en, otherwise the result.
- i_wdata  input  WORD_WD  store data (rs2).
- i_mem_en  input  1  instruction is a load or store.
- i_mem_op  input  4  [3] store, [2] unsigned load, [1:0] size (0=B, 1=H, 2=W, 3=D).
- o_mem_req_valid  output  1  memory request valid.
- i_mem_req_ready  input  1  memory accepts request.
- o_mem_addr  output  WORD_WD  address with [2:0] forced to 0.
- o_mem_wen  output  1  request is a write.
- o_mem_wdata  output  WORD_WD  i_wdata shifted left by 8*addr[2:0].
- o_mem_wmask  output  8  byte-lane mask: (1,3,F,FF)[size] shifted left by addr[2:0]; 0 for loads.
- i_mem_rsp_valid  input  1  response/ack valid, one cycle per request.
- i_mem_rdata  input  WORD_WD  aligned 64-bit read data.
- o_valid  output  1  result valid to write-back.
- i_wb_ready  input  1  write-back accepts.
- o_result  output  WORD_WD  pass-through value, extended load data, or 0 for a store or a misaligned access.
- o_misalign  output  1  access was misaligned, qualified by o_valid.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset forces IDLE from any state, including mid-request.
- IDLE: accept when i_valid && o_ready. All inputs are captured into registers at acceptance.
  - Non-memory instruction: result = i_alu_result; next state DONE.
  - Misaligned access (addr mod 2^size != 0): result = 0, misalign = 1; next state DONE; no memory request is issued.
  - Otherwise: next state REQ.
- REQ: o_mem_req_valid = 1, with address, wen, wdata and wmask held stable until i_mem_req_ready. On the handshake, next state WAIT.
- WAIT: wait for i_mem_rsp_valid.
  - Load: select byte lane data = i_mem_rdata >> 8*addr[2:0], truncate to the access size, then sign-extend, or zero-extend when op[2] is set.
  - D-size load ignores op[2].
  - Store: result = 0.
  - Next state DONE.
- DONE: o_valid = 1, with o_result and o_misalign held stable until i_wb_ready; then IDLE.
- i_mem_rsp_valid is ignored in every state other than WAIT. i_mem_rdata is ignored for stores.
- Unsigned bit with the store bit set is a don't-care.

## Timing
- Reset values:
  - state = IDLE; o_ready = 1.
  - o_mem_req_valid = 0, o_mem_wen = 0, o_mem_wmask = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - o_valid = 0, o_result = 0, o_misalign = 0.
- All outputs are driven from registers or decoded from state. There is no combinational path from any input to any output.
- Non-memory or misaligned instruction: accept at cycle 0, o_valid at cycle 1.
- Memory access with a zero-wait port: accept at cycle 0, request handshake at cycle 1, response at cycle 2, o_valid at cycle 3.
  - The response is sampled no earlier than the cycle after the request handshake.
- Back-to-back throughput: one instruction per (latency + 1) cycles. The next accept can occur the cycle after DONE drains.
- Stalls:
  - A held-low i_mem_req_ready stalls in REQ indefinitely with outputs stable.
  - A held-low i_wb_ready stalls in DONE indefinitely with outputs stable.

## Test plan
- Reset, then a non-memory op with i_alu_result = 0x1234 → o_valid at cycle 1, o_result = 0x1234, no memory request; output held for 3 cycles while i_wb_ready = 0.
- LB at addr 0x80000003, rdata = 0x00000000_80FF0000 → wmask 0, o_mem_addr = 0x80000000, o_result = 0xFFFFFFFF_FFFFFF80. Same access as LBU → 0x80.
- SH at addr 0x80000006, wdata = 0xABCD → o_mem_wen = 1, wmask = 0xC0, wdata = 0xABCD0000_00000000, o_result = 0.
- LW at addr 0x80000002 → o_misalign = 1, o_result = 0, o_mem_req_valid never asserted.
- LD with i_mem_req_ready low for 4 cycles and response 5 cycles later → request fields stable throughout, o_result = rdata.
- i_rst asserted while in WAIT → next cycle IDLE with all outputs at reset values. A stray i_mem_rsp_valid is then ignored, and a following op completes normally.
